// File: rtl/writeback_regfile.sv
// Write-back select mux plus NUM_REGS x DATA_W register file with two combinational read ports.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to the read ports; undefined = array-only reads.
module writeback_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wb_readvalue,
  input  logic [DATA_W-1:0] wb_aluvalue,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_memtoreg,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_commit
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_sel;
  logic                wr_live;
  logic                wb_commit_q;
  logic                wb_commit_d;

  assign wb_data = wb_memtoreg ? wb_readvalue : wb_aluvalue;

  // A write only counts when enabled and not aimed at the hardwired zero register.
  assign wr_live     = wb_regwrite && (wb_rd != '0);
  assign wb_commit_d = wr_live && !reset;

  // One-hot write decode; entry 0 is never selected so it stays at its reset value of zero.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
      if (gi == 0) begin : g_zero
        assign wr_sel[gi] = 1'b0;
      end else begin : g_live
        assign wr_sel[gi] = wr_live && (wb_rd == ADDR_W'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wb_commit_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          regs_q[i] <= wb_data;
        end
      end
      wb_commit_q <= wb_commit_d;
    end
  end

  assign wb_commit = wb_commit_q;

`ifdef REGFILE_BYPASS_EN
  logic rs_hit;
  logic rt_hit;

  // wr_live already excludes address 0, so register 0 is never bypassed.
  assign rs_hit  = wr_live && !reset && (wb_rd == rs_addr);
  assign rt_hit  = wr_live && !reset && (wb_rd == rt_addr);
  assign rs_data = rs_hit ? wb_data : regs_q[rs_addr];
  assign rt_data = rt_hit ? wb_data : regs_q[rt_addr];
`else
  assign rs_data = regs_q[rs_addr];
  assign rt_data = regs_q[rt_addr];
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reset, ALU/load writes, x0, same-cycle RAW, reset collision.
// Expectations for the same-cycle RAW step follow REGFILE_BYPASS_EN.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_readvalue;
  logic [31:0] wb_aluvalue;
  logic [4:0]  wb_rd;
  logic        wb_memtoreg;
  logic        wb_regwrite;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_commit;

  int n_cmp = 0;
  int n_err = 0;

  writeback_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .wb_readvalue (wb_readvalue),
    .wb_aluvalue  (wb_aluvalue),
    .wb_rd        (wb_rd),
    .wb_memtoreg  (wb_memtoreg),
    .wb_regwrite  (wb_regwrite),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .wb_data      (wb_data),
    .wb_commit    (wb_commit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] raw_exp;

  initial begin
    reset        = 1'b1;
    wb_readvalue = 32'h0;
    wb_aluvalue  = 32'h1;
    wb_rd        = 5'd3;
    wb_memtoreg  = 1'b0;
    wb_regwrite  = 1'b1;
    rs_addr      = 5'd0;
    rt_addr      = 5'd0;

    // Reset held two cycles with a write to r3 pending; both writes are discarded.
    @(posedge clk); @(posedge clk); #1;
    chk("reset_commit", {31'b0, wb_commit}, 32'h0);
    @(negedge clk);
    reset       = 1'b0;
    wb_regwrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      chk($sformatf("reset_rs[%0d]", i), rs_data, 32'h0);
      chk($sformatf("reset_rt[%0d]", 31 - i), rt_data, 32'h0);
    end
    chk("reset_commit_idle", {31'b0, wb_commit}, 32'h0);

    // ALU write to r5.
    @(negedge clk);
    wb_memtoreg  = 1'b0;
    wb_aluvalue  = 32'h0000_1234;
    wb_readvalue = 32'hDEAD_BEEF;
    wb_rd        = 5'd5;
    wb_regwrite  = 1'b1;
    #1 chk("alu_wb_data", wb_data, 32'h0000_1234);
    @(posedge clk); #1;
    wb_regwrite = 1'b0;
    rs_addr     = 5'd5;
    #1;
    chk("alu_rs5", rs_data, 32'h0000_1234);
    chk("alu_commit", {31'b0, wb_commit}, 32'h1);
    @(posedge clk); #1;
    chk("alu_commit_drop", {31'b0, wb_commit}, 32'h0);

    // Load write to r31.
    @(negedge clk);
    wb_memtoreg  = 1'b1;
    wb_readvalue = 32'hCAFE_F00D;
    wb_aluvalue  = 32'h1111_2222;
    wb_rd        = 5'd31;
    wb_regwrite  = 1'b1;
    #1 chk("load_wb_data", wb_data, 32'hCAFE_F00D);
    @(posedge clk); #1;
    wb_regwrite = 1'b0;
    rt_addr     = 5'd31;
    #1;
    chk("load_rt31", rt_data, 32'hCAFE_F00D);
    chk("load_commit", {31'b0, wb_commit}, 32'h1);
    chk("load_rs5_kept", rs_data, 32'h0000_1234);

    // Attempted write to x0.
    @(negedge clk);
    wb_memtoreg = 1'b0;
    wb_aluvalue = 32'hFFFF_FFFF;
    wb_rd       = 5'd0;
    wb_regwrite = 1'b1;
    rs_addr     = 5'd0;
    #1 chk("x0_same_cycle", rs_data, 32'h0);
    @(posedge clk); #1;
    wb_regwrite = 1'b0;
    #1;
    chk("x0_after", rs_data, 32'h0);
    chk("x0_commit", {31'b0, wb_commit}, 32'h0);

    // Same-cycle RAW on r7, both ports.
    @(negedge clk);
    wb_aluvalue = 32'h55AA_55AA;
    wb_rd       = 5'd7;
    wb_regwrite = 1'b1;
    rs_addr     = 5'd7;
    rt_addr     = 5'd7;
`ifdef REGFILE_BYPASS_EN
    raw_exp = 32'h55AA_55AA;
`else
    raw_exp = 32'h0;
`endif
    #1;
    chk("raw_rs_same", rs_data, raw_exp);
    chk("raw_rt_same", rt_data, raw_exp);
    @(posedge clk); #1;
    wb_regwrite = 1'b0;
    #1;
    chk("raw_rs_next", rs_data, 32'h55AA_55AA);
    chk("raw_rt_next", rt_data, 32'h55AA_55AA);

    // r9 written, then a disabled write must leave it alone.
    @(negedge clk);
    wb_aluvalue = 32'h0000_0099;
    wb_rd       = 5'd9;
    wb_regwrite = 1'b1;
    @(negedge clk);
    wb_aluvalue = 32'h0000_0077;
    wb_regwrite = 1'b0;
    rs_addr     = 5'd9;
    @(posedge clk); #1;
    chk("noen_r9", rs_data, 32'h0000_0099);
    chk("noen_commit", {31'b0, wb_commit}, 32'h0);

    // Reset collision: write to r3 during reset is lost; reset clears r5/r9.
    @(negedge clk);
    reset       = 1'b1;
    wb_aluvalue = 32'h0000_0001;
    wb_rd       = 5'd3;
    wb_regwrite = 1'b1;
    rs_addr     = 5'd3;
    #1 chk("rst_bypass_off", rs_data, 32'h0);
    @(posedge clk); #1;
    rt_addr = 5'd9;
    #1;
    chk("rst_r3", rs_data, 32'h0);
    chk("rst_r9", rt_data, 32'h0);
    chk("rst_commit", {31'b0, wb_commit}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rt_addr = 5'd5;
    #1 chk("rst_r5", rt_data, 32'h0);
    // First posedge with reset low takes the pending write.
    @(posedge clk); #1;
    wb_regwrite = 1'b0;
    #1;
    chk("post_rst_r3", rs_data, 32'h0000_0001);
    chk("post_rst_commit", {31'b0, wb_commit}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
